// File: rtl/crt_timing.sv
// Raster timing generator: pixel/line counters with registered sync, blank and pulse decode.
// Optional composite sync output enabled by defining CRT_CSYNC_EN.
module crt_timing #(
  parameter int unsigned H_ACTIVE = 768,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 70,
  parameter int unsigned H_BP     = 82,
  parameter int unsigned V_ACTIVE = 288,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pxclk,
  input  logic       med_res,
  output logic [9:0] hpos,
  output logic [8:0] vpos,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start
`ifdef CRT_CSYNC_EN
  ,
  output logic       csync_n
`endif
);

  typedef enum logic {
    MODE_LOW = 1'b0,
    MODE_MED = 1'b1
  } mode_e;

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Low-res limits are the medium-res ones halved; all inputs are even so sums halve exactly.
  localparam logic [10:0] HT_M1_MED  = 11'(HT - 1);
  localparam logic [10:0] HT_M1_LOW  = 11'(HT / 2 - 1);
  localparam logic [10:0] HA_MED     = 11'(H_ACTIVE);
  localparam logic [10:0] HA_LOW     = 11'(H_ACTIVE / 2);
  localparam logic [10:0] HS_ON_MED  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_ON_LOW  = 11'((H_ACTIVE + H_FP) / 2);
  localparam logic [10:0] HS_OFF_MED = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HS_OFF_LOW = 11'((H_ACTIVE + H_FP + H_SYNC) / 2);

  localparam logic [9:0]  VA         = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON      = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0]  VT_M1      = 9'(VT - 1);

  mode_e       mode_q;
  mode_e       mode_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  h_nxt;
  logic [8:0]  v_nxt;
  logic [10:0] ht_m1;
  logic [10:0] ha;
  logic [10:0] hs_on;
  logic [10:0] hs_off;
  logic        hsync_nxt;
  logic        vsync_act;
  logic        blank_nxt;

  // Line length uses the mode of the current line; decode uses the mode the next count belongs to.
  always_comb begin
    ht_m1     = (mode_q == MODE_MED) ? HT_M1_MED : HT_M1_LOW;
    h_wrap    = ({1'b0, hpos} == ht_m1);
    v_wrap    = (vpos == VT_M1);
    h_nxt     = h_wrap ? '0 : hpos + 10'd1;
    v_nxt     = vpos;
    mode_nxt  = mode_q;
    if (h_wrap) begin
      v_nxt    = v_wrap ? '0 : vpos + 9'd1;
      mode_nxt = med_res ? MODE_MED : MODE_LOW;
    end

    ha     = (mode_nxt == MODE_MED) ? HA_MED     : HA_LOW;
    hs_on  = (mode_nxt == MODE_MED) ? HS_ON_MED  : HS_ON_LOW;
    hs_off = (mode_nxt == MODE_MED) ? HS_OFF_MED : HS_OFF_LOW;

    hsync_nxt = !(({1'b0, h_nxt} >= hs_on) && ({1'b0, h_nxt} < hs_off));
    vsync_act = ({1'b0, v_nxt} >= VS_ON) && ({1'b0, v_nxt} < VS_OFF);
    blank_nxt = ({1'b0, h_nxt} >= ha) || ({1'b0, v_nxt} >= VA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      mode_q      <= med_res ? MODE_MED : MODE_LOW;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pxclk) begin
        hpos        <= h_nxt;
        vpos        <= v_nxt;
        mode_q      <= mode_nxt;
        hsync_n     <= hsync_nxt;
        vsync_n     <= !vsync_act;
        blank       <= blank_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

`ifdef CRT_CSYNC_EN
  // Serrated composite sync: hsync is inverted across the vsync lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      csync_n <= 1'b1;
    end else if (pxclk) begin
      csync_n <= vsync_act ? !hsync_nxt : hsync_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_crt_timing.sv
// Scoreboard bench for crt_timing: default-size and reduced-size instances vs. a behavioural raster model.
module tb_crt_timing;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int h, v;
    bit mode;
  } st_t;

  typedef struct packed {
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic       csync_n;
  } exp_t;

  localparam cfg_t CFG_DEF = '{768, 24, 70, 82, 288, 4, 3, 17};
  localparam cfg_t CFG_SML = '{64, 8, 10, 14, 20, 2, 3, 3};
  localparam int SML_VT = 28;

  logic clk = 1'b0;
  logic reset, pxclk, med_res;

  logic [9:0] d_hpos, s_hpos;
  logic [8:0] d_vpos, s_vpos;
  logic d_hs, d_vs, d_bl, d_ls, d_fs, d_cs;
  logic s_hs, s_vs, s_bl, s_ls, s_fs, s_cs;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  st_t sd, ss;
  exp_t ed, es;
  exp_t q_def[$];
  exp_t q_sml[$];
  int sml_lines = 0;
  bit sml_seen = 1'b0;

  always #5 clk = ~clk;

  crt_timing dut_def (
    .clk(clk), .reset(reset), .pxclk(pxclk), .med_res(med_res),
    .hpos(d_hpos), .vpos(d_vpos), .hsync_n(d_hs), .vsync_n(d_vs), .blank(d_bl),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef CRT_CSYNC_EN
    , .csync_n(d_cs)
`endif
  );

  crt_timing #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(10), .H_BP(14),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(3)
  ) dut_sml (
    .clk(clk), .reset(reset), .pxclk(pxclk), .med_res(med_res),
    .hpos(s_hpos), .vpos(s_vpos), .hsync_n(s_hs), .vsync_n(s_vs), .blank(s_bl),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef CRT_CSYNC_EN
    , .csync_n(s_cs)
`endif
  );

`ifndef CRT_CSYNC_EN
  assign d_cs = 1'b1;
  assign s_cs = 1'b1;
`endif

  // Behavioural raster model: one pixel-enable step, outputs reflect the count after the step.
  function automatic void step(input cfg_t c, input st_t si, input bit rst, input bit en,
                               input bit mr, input exp_t oi, output st_t so, output exp_t oo);
    int ht, ha, hs0, hs1, vt;
    bit wrapped, in_vs;
    so = si;
    oo = oi;
    if (rst) begin
      so.h = 0; so.v = 0; so.mode = mr;
      oo = '{hpos: '0, vpos: '0, hsync_n: 1'b1, vsync_n: 1'b1, blank: 1'b0,
             line_start: 1'b0, frame_start: 1'b0, csync_n: 1'b1};
      return;
    end
    oo.line_start = 1'b0;
    oo.frame_start = 1'b0;
    if (!en) return;
    vt = c.va + c.vf + c.vs + c.vb;
    ht = c.ha + c.hf + c.hs + c.hb;
    if (!so.mode) ht = (c.ha / 2) + (c.hf / 2) + (c.hs / 2) + (c.hb / 2);
    so.h = so.h + 1;
    wrapped = 1'b0;
    if (so.h == ht) begin
      so.h = 0;
      so.v = (so.v + 1) % vt;
      so.mode = mr;
      wrapped = 1'b1;
    end
    ha = so.mode ? c.ha : c.ha / 2;
    hs0 = ha + (so.mode ? c.hf : c.hf / 2);
    hs1 = hs0 + (so.mode ? c.hs : c.hs / 2);
    in_vs = (so.v >= c.va + c.vf) && (so.v < c.va + c.vf + c.vs);
    oo.hpos = 10'(so.h);
    oo.vpos = 9'(so.v);
    oo.hsync_n = !(so.h >= hs0 && so.h < hs1);
    oo.vsync_n = !in_vs;
    oo.blank = (so.h >= ha) || (so.v >= c.va);
    oo.line_start = wrapped;
    oo.frame_start = wrapped && (so.v == 0);
`ifdef CRT_CSYNC_EN
    oo.csync_n = in_vs ? !oo.hsync_n : oo.hsync_n;
`else
    oo.csync_n = 1'b1;
`endif
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual/expected hpos=%0d/%0d vpos=%0d/%0d hs=%b/%b vs=%b/%b bl=%b/%b ls=%b/%b fs=%b/%b cs=%b/%b",
               name, $time, act.hpos, exp.hpos, act.vpos, exp.vpos, act.hsync_n, exp.hsync_n,
               act.vsync_n, exp.vsync_n, act.blank, exp.blank, act.line_start, exp.line_start,
               act.frame_start, exp.frame_start, act.csync_n, exp.csync_n);
    end
  endtask

  // Stimulus side: advance the model and queue the expected response for this edge.
  always @(posedge clk) begin
    if (run) begin
      step(CFG_DEF, sd, reset, pxclk, med_res, ed, sd, ed);
      q_def.push_back(ed);
      step(CFG_SML, ss, reset, pxclk, med_res, es, ss, es);
      q_sml.push_back(es);
    end
  end

  // Monitor side: every edge presents a registered output set for each instance.
  always @(posedge clk) begin
    if (run) begin
      #1;
      if (q_def.size() == 0) begin
        checks++; errors++;
        $display("FAIL def_queue_empty t=%0t", $time);
      end else begin
        compare("def_outputs", {d_hpos, d_vpos, d_hs, d_vs, d_bl, d_ls, d_fs, d_cs}, q_def.pop_front());
      end
      if (q_sml.size() == 0) begin
        checks++; errors++;
        $display("FAIL sml_queue_empty t=%0t", $time);
      end else begin
        compare("sml_outputs", {s_hpos, s_vpos, s_hs, s_vs, s_bl, s_ls, s_fs, s_cs}, q_sml.pop_front());
      end
      if (reset) begin
        sml_lines = 0;
        sml_seen = 1'b0;
      end else begin
        if (s_ls) sml_lines++;
        if (s_fs) begin
          if (sml_seen) begin
            checks++;
            if (sml_lines != SML_VT) begin
              errors++;
              $display("FAIL sml_lines_per_frame actual=%0d expected=%0d", sml_lines, SML_VT);
            end
          end
          sml_seen = 1'b1;
          sml_lines = 0;
        end
      end
    end
  end

  // pat: 0 = pxclk held high, 1 = toggling, 2 = random
  task automatic drive(input int pat);
    @(negedge clk);
    case (pat)
      0: pxclk = 1'b1;
      1: pxclk = ~pxclk;
      default: pxclk = ($urandom_range(0, 9) < 6);
    endcase
  endtask

  task automatic cycles(input int n, input int pat, input bit mr);
    for (int i = 0; i < n; i++) begin
      drive(pat);
      med_res = mr;
    end
  endtask

  task automatic wait_def_h(input int target, input int pat, input int budget);
    int n;
    n = 0;
    while (sd.h != target && n < budget) begin
      drive(pat);
      n++;
    end
    if (sd.h != target) begin
      checks++; errors++;
      $display("FAIL wait_def_hpos actual=%0d expected=%0d", sd.h, target);
    end
  endtask

  task automatic wait_sml_sync(input int budget);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      drive(0);
      n++;
      hit = (ss.v >= 22) && (ss.v < 25) && ss.mode && (ss.h >= 72) && (ss.h < 82);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_sml_sync actual_v=%0d actual_h=%0d expected=in_sync", ss.v, ss.h);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pxclk = 1'b0;
    med_res = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    cycles(3 * 944 + 5, 0, 1'b1);          // medium res, continuous enable
    cycles(2 * 944, 1, 1'b0);              // low res, toggling enable
    cycles(3 * 944, 1, 1'b0);

    wait_def_h(300, 1, 2000);              // mid-line switch low -> medium
    med_res = 1'b1;
    cycles(3 * 944, 0, 1'b1);
    wait_def_h(300, 0, 2000);              // mid-line switch medium -> low
    med_res = 1'b0;
    cycles(3 * 944, 1, 1'b0);

    cycles(1500, 0, 1'b0);                 // low res with pxclk held high

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) med_res = ~med_res;
      cycles(400, 2, med_res);
    end

    cycles(1000, 0, 1'b1);
    wait_sml_sync(6000);                   // reset inside hsync of a vsync line
    pulse_reset();
    cycles(3000, 0, 1'b1);
    wait_def_h(800, 0, 2000);              // reset inside hsync
    pulse_reset();
    cycles(2000, 1, 1'b0);

    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (q_def.size() != 0 || q_sml.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d/%0d expected=0/0", q_def.size(), q_sml.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
